// File: rtl/discharge_status_reporter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | discharge_status_reporter: per-cycle discharge measurements -> 16b frame |
// | Optional checksum word W4: define STATUS_REPORT_CHECKSUM_EN. Rev 1.0     |
// +--------------------------------------------------------------------------+
module discharge_status_reporter #(
  parameter logic [7:0]  FRAME_HEADER      = 8'hA5,
  parameter logic [15:0] MAX_CURRENT_LIMIT = 16'd78,
  parameter logic [15:0] SAT_MAX           = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               report_enable,
  input  logic               is_operation,
  input  logic               is_breakdown,
  input  logic signed [15:0] sample_current,
  input  logic               tx_ready,
  output logic               tx_valid,
  output logic [15:0]        tx_data,
  output logic               tx_last,
  output logic [15:0]        drop_count,
  output logic               busy
);

`ifdef STATUS_REPORT_CHECKSUM_EN
  localparam int c_NUM_WORDS = 5;
`else
  localparam int c_NUM_WORDS = 4;
`endif
  localparam int                 c_IDX_W    = $clog2(c_NUM_WORDS);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic               r_op_d, r_bd_d;
  logic               r_armed, r_bd_seen, r_end, r_ovf;
  logic [15:0]        r_ign, r_width, r_peak;
  logic [3:0]         r_seq;
  logic [c_IDX_W-1:0] r_idx;
  logic [15:0]        r_words [c_NUM_WORDS];

  logic w_op_rise, w_op_fall, w_bd_rise, w_start, w_end, w_counting, w_handshake;
  logic w_over_current, w_open;
  logic [15:0] w_w0, w_w1;

  assign w_op_rise   = is_operation & ~r_op_d;
  assign w_op_fall   = ~is_operation & r_op_d;
  assign w_bd_rise   = is_breakdown & ~r_bd_d;
  assign w_start     = w_op_rise & report_enable;
  assign w_end       = r_armed & w_op_fall & report_enable;
  assign w_counting  = r_armed & is_operation & report_enable;
  assign w_handshake = tx_valid & tx_ready;

  // r_peak is never negative, so an unsigned compare against the limit is exact
  assign w_over_current = r_peak > MAX_CURRENT_LIMIT;
  assign w_open         = ~r_bd_seen;
  assign w_w0 = {FRAME_HEADER, r_seq, w_over_current, r_ovf, w_open, r_bd_seen};
  assign w_w1 = w_open ? SAT_MAX : r_ign;

  // Measurement of the current discharge cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_d    <= 1'b0;
      r_bd_d    <= 1'b0;
      r_armed   <= 1'b0;
      r_bd_seen <= 1'b0;
      r_end     <= 1'b0;
      r_ign     <= '0;
      r_width   <= '0;
      r_peak    <= '0;
    end else begin
      r_op_d <= is_operation;
      r_bd_d <= is_breakdown;
      r_end  <= w_end;
      if (w_start) begin
        r_armed   <= 1'b1;
        r_bd_seen <= is_breakdown;
        // Start edge is the first counted clk of the ignition delay
        r_ign     <= w_bd_rise ? 16'd0 : 16'd1;
        r_width   <= is_breakdown ? 16'd1 : 16'd0;
        r_peak    <= (is_breakdown && !sample_current[15]) ? sample_current : '0;
      end else if (r_armed && !report_enable) begin
        r_armed <= 1'b0;
      end else if (w_end) begin
        r_armed <= 1'b0;
        if (w_bd_rise) r_bd_seen <= 1'b1;
      end else if (w_counting) begin
        if (w_bd_rise) r_bd_seen <= 1'b1;
        if (!r_bd_seen && !w_bd_rise && r_ign != SAT_MAX) r_ign <= r_ign + 16'd1;
        if (is_breakdown) begin
          if (r_width != SAT_MAX) r_width <= r_width + 16'd1;
          if (sample_current > $signed(r_peak)) r_peak <= sample_current;
        end
      end
    end
  end

  // Record latch, drop accounting and word sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ovf      <= 1'b0;
      r_seq      <= '0;
      r_idx      <= '0;
      drop_count <= '0;
      for (int i = 0; i < c_NUM_WORDS; i++) r_words[i] <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_end) begin
        if (r_state == ST_IDLE) begin
          r_words[0] <= w_w0;
          r_words[1] <= w_w1;
          r_words[2] <= r_peak;
          r_words[3] <= r_width;
`ifdef STATUS_REPORT_CHECKSUM_EN
          r_words[4] <= w_w0 ^ w_w1 ^ r_peak ^ r_width;
`endif
          r_ovf <= 1'b0;
        end else begin
          r_ovf <= 1'b1;
          if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
      end
      if (w_handshake) begin
        if (r_idx == c_LAST_IDX) begin
          r_idx <= '0;
          r_seq <= r_seq + 4'd1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    tx_valid     = 1'b0;
    tx_data      = '0;
    tx_last      = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (r_end) w_state_next = ST_LOAD;
      end
      ST_LOAD: w_state_next = ST_SEND;
      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = r_words[r_idx];
        tx_last  = (r_idx == c_LAST_IDX);
        if (tx_ready && r_idx == c_LAST_IDX) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire
